// File: rtl/triangle_raster_scheduler.sv
// rtl/triangle_raster_scheduler.sv - walks a clamped triangle bounding box and feeds the interpolator
// Shared stream types live in the package; the scheduler module follows it.

package triangle_raster_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t     v0;
    vertex_t     v1;
    vertex_t     v2;
    logic [15:0] attr0;
    logic [15:0] attr1;
    logic [15:0] attr2;
    logic [31:0] area_inv;
  } attributed_triangle_t;

  typedef struct packed {
    logic last;
  } triangle_metadata_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pixel_coordinate_t;

  typedef struct packed {
    logic last;
  } pixel_metadata_t;

  typedef struct packed {
    logic [15:0] min_x;
    logic [15:0] min_y;
    logic [15:0] max_x;
    logic [15:0] max_y;
  } bbox_t;

endpackage

module triangle_raster_scheduler
  import triangle_raster_pkg::*;
#(
  parameter int VIEWPORT_WIDTH  = 160,
  parameter int VIEWPORT_HEIGHT = 120
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 triangle_s_ready,
  input  logic                 triangle_s_valid,
  input  attributed_triangle_t triangle_s_data,
  input  triangle_metadata_t   triangle_s_metadata,
  input  bbox_t                bbox_s_data,
  input  logic                 attributed_triangle_m_ready,
  output logic                 attributed_triangle_m_valid,
  output attributed_triangle_t attributed_triangle_m_data,
  output triangle_metadata_t   attributed_triangle_m_metadata,
  input  logic                 pixel_coordinate_m_ready,
  output logic                 pixel_coordinate_m_valid,
  output pixel_coordinate_t    pixel_coordinate_m_data,
  output pixel_metadata_t      pixel_coordinate_m_metadata,
  output logic                 busy
);

  localparam logic signed [15:0] X_LIMIT = 16'(VIEWPORT_WIDTH - 1);
  localparam logic signed [15:0] Y_LIMIT = 16'(VIEWPORT_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  attributed_triangle_t trg_q, trg_d;
  triangle_metadata_t   meta_q, meta_d;
  logic signed [15:0]   cmin_x_q, cmin_x_d;
  logic signed [15:0]   cmax_x_q, cmax_x_d;
  logic signed [15:0]   cmax_y_q, cmax_y_d;
  logic signed [15:0]   x_q, x_d;
  logic signed [15:0]   y_q, y_d;
  logic                 first_q, first_d;

  logic signed [15:0] min_x_s, min_y_s, max_x_s, max_y_s;
  logic signed [15:0] cmin_x, cmin_y, cmax_x, cmax_y;
  logic               box_empty;
  logic               pix_valid, trg_valid, beat_xfer, last_pix;

  // Viewport clamp of the incoming box, evaluated in signed 16-bit arithmetic.
  always_comb begin
    min_x_s   = $signed(bbox_s_data.min_x);
    min_y_s   = $signed(bbox_s_data.min_y);
    max_x_s   = $signed(bbox_s_data.max_x);
    max_y_s   = $signed(bbox_s_data.max_y);
    cmin_x    = (min_x_s < 16'sd0) ? 16'sd0 : min_x_s;
    cmin_y    = (min_y_s < 16'sd0) ? 16'sd0 : min_y_s;
    cmax_x    = (max_x_s > X_LIMIT) ? X_LIMIT : max_x_s;
    cmax_y    = (max_y_s > Y_LIMIT) ? Y_LIMIT : max_y_s;
    box_empty = (cmin_x > cmax_x) || (cmin_y > cmax_y);
  end

  // The triangle rides only on the first beat of a scan, or on the lone flush beat.
  always_comb begin
    pix_valid = (state_q != IDLE);
    trg_valid = ((state_q == SCAN) && first_q) || (state_q == FLUSH);
    beat_xfer = pix_valid && pixel_coordinate_m_ready
                && (!trg_valid || attributed_triangle_m_ready);
    last_pix  = (x_q == cmax_x_q) && (y_q == cmax_y_q);
  end

  always_comb begin
    state_d  = state_q;
    trg_d    = trg_q;
    meta_d   = meta_q;
    cmin_x_d = cmin_x_q;
    cmax_x_d = cmax_x_q;
    cmax_y_d = cmax_y_q;
    x_d      = x_q;
    y_d      = y_q;
    first_d  = first_q;
    case (state_q)
      IDLE: begin
        if (triangle_s_valid) begin
          trg_d    = triangle_s_data;
          meta_d   = triangle_s_metadata;
          cmin_x_d = cmin_x;
          cmax_x_d = cmax_x;
          cmax_y_d = cmax_y;
          x_d      = cmin_x;
          y_d      = cmin_y;
          first_d  = 1'b1;
          if (!box_empty) begin
            state_d = SCAN;
          end else if (triangle_s_metadata.last) begin
            state_d = FLUSH;
          end
        end
      end
      SCAN: begin
        if (beat_xfer) begin
          first_d = 1'b0;
          if (x_q < cmax_x_q) begin
            x_d = x_q + 16'sd1;
          end else begin
            x_d = cmin_x_q;
            y_d = y_q + 16'sd1;
          end
          if (last_pix) begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (beat_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      trg_q    <= '0;
      meta_q   <= '0;
      cmin_x_q <= '0;
      cmax_x_q <= '0;
      cmax_y_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      trg_q    <= trg_d;
      meta_q   <= meta_d;
      cmin_x_q <= cmin_x_d;
      cmax_x_q <= cmax_x_d;
      cmax_y_q <= cmax_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
      first_q  <= first_d;
    end
  end

  // Flush beat: zero triangle at (0,0) so coverage is 0 but the frame-end marker survives.
  always_comb begin
    triangle_s_ready                    = (state_q == IDLE);
    busy                                = (state_q != IDLE);
    pixel_coordinate_m_valid            = pix_valid;
    attributed_triangle_m_valid         = trg_valid;
    attributed_triangle_m_data          = (state_q == FLUSH) ? '0 : trg_q;
    attributed_triangle_m_metadata.last = (state_q == FLUSH) ? 1'b1 : meta_q.last;
    pixel_coordinate_m_data.x           = (state_q == FLUSH) ? 16'd0 : x_q;
    pixel_coordinate_m_data.y           = (state_q == FLUSH) ? 16'd0 : y_q;
    pixel_coordinate_m_metadata.last    = (state_q == FLUSH) || ((state_q == SCAN) && last_pix);
  end

endmodule

// File: tb/tb_triangle_raster_scheduler.sv
// tb/tb_triangle_raster_scheduler.sv - self-checking bench for triangle_raster_scheduler
// Table vectors, hand-built stall/reset sequences and random boxes checked against a pixel-list model.

module tb_triangle_raster_scheduler;
  import triangle_raster_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic                 clk;
  logic                 rstn;
  logic                 triangle_s_ready;
  logic                 triangle_s_valid;
  attributed_triangle_t triangle_s_data;
  triangle_metadata_t   triangle_s_metadata;
  bbox_t                bbox_s_data;
  logic                 attributed_triangle_m_ready;
  logic                 attributed_triangle_m_valid;
  attributed_triangle_t attributed_triangle_m_data;
  triangle_metadata_t   attributed_triangle_m_metadata;
  logic                 pixel_coordinate_m_ready;
  logic                 pixel_coordinate_m_valid;
  pixel_coordinate_t    pixel_coordinate_m_data;
  pixel_metadata_t      pixel_coordinate_m_metadata;
  logic                 busy;

  triangle_raster_scheduler #(
    .VIEWPORT_WIDTH (W),
    .VIEWPORT_HEIGHT(H)
  ) dut (
    .clk                           (clk),
    .rstn                          (rstn),
    .triangle_s_ready              (triangle_s_ready),
    .triangle_s_valid              (triangle_s_valid),
    .triangle_s_data               (triangle_s_data),
    .triangle_s_metadata           (triangle_s_metadata),
    .bbox_s_data                   (bbox_s_data),
    .attributed_triangle_m_ready   (attributed_triangle_m_ready),
    .attributed_triangle_m_valid   (attributed_triangle_m_valid),
    .attributed_triangle_m_data    (attributed_triangle_m_data),
    .attributed_triangle_m_metadata(attributed_triangle_m_metadata),
    .pixel_coordinate_m_ready      (pixel_coordinate_m_ready),
    .pixel_coordinate_m_valid      (pixel_coordinate_m_valid),
    .pixel_coordinate_m_data       (pixel_coordinate_m_data),
    .pixel_coordinate_m_metadata   (pixel_coordinate_m_metadata),
    .busy                          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]          x;
    logic [15:0]          y;
    logic                 plast;
    logic                 tvalid;
    attributed_triangle_t trg;
    logic                 tlast;
  } beat_t;

  typedef struct {
    int mnx, mny, mxx, mxy;
    int lst;
    int n;
    int fx, fy, ex, ey;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected beats listed straight from the clamped box, row by row.
  task automatic build_model(input int mnx, input int mny, input int mxx, input int mxy,
                             input int lst, input attributed_triangle_t trg);
    int    cx0, cy0, cx1, cy1;
    beat_t b;
    exp_q.delete();
    cx0 = (mnx < 0) ? 0 : mnx;
    cy0 = (mny < 0) ? 0 : mny;
    cx1 = (mxx > W - 1) ? W - 1 : mxx;
    cy1 = (mxy > H - 1) ? H - 1 : mxy;
    if (cx0 > cx1 || cy0 > cy1) begin
      if (lst != 0) begin
        b.x = 16'd0; b.y = 16'd0; b.plast = 1'b1; b.tvalid = 1'b1;
        b.trg = '0; b.tlast = 1'b1;
        exp_q.push_back(b);
      end
    end else begin
      for (int yy = cy0; yy <= cy1; yy++) begin
        for (int xx = cx0; xx <= cx1; xx++) begin
          b.x      = 16'(xx);
          b.y      = 16'(yy);
          b.plast  = (xx == cx1) && (yy == cy1);
          b.tvalid = (xx == cx0) && (yy == cy0);
          b.trg    = trg;
          b.tlast  = (lst != 0);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  task automatic drive_tri(input int mnx, input int mny, input int mxx, input int mxy,
                           input int lst, input attributed_triangle_t trg);
    triangle_s_valid         = 1'b1;
    triangle_s_data          = trg;
    triangle_s_metadata.last = (lst != 0);
    bbox_s_data.min_x        = 16'(mnx);
    bbox_s_data.min_y        = 16'(mny);
    bbox_s_data.max_x        = 16'(mxx);
    bbox_s_data.max_y        = 16'(mxy);
  endtask

  // mode 0: always ready; 1: random readies; 2: pixel ready low 3 cycles on beat 1;
  // 3: attributed ready low 2 cycles while the triangle beat is offered.
  task automatic run_tri(input int mnx, input int mny, input int mxx, input int mxy,
                         input int lst, input int mode,
                         output int nb, output int nc,
                         output int fx, output int fy, output int ex, output int ey);
    attributed_triangle_t trg;
    logic [319:0]         cur, prev;
    logic                 have_prev, prdy, trdy, xfer;
    int                   stall;
    beat_t                e;
    trg = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    build_model(mnx, mny, mxx, mxy, lst, trg);
    nb = 0; nc = 0; fx = -1; fy = -1; ex = -1; ey = -1;
    stall = 0; have_prev = 1'b0; prev = '0;
    @(negedge clk);
    check("s_ready_idle", 320'(triangle_s_ready), 320'(1));
    drive_tri(mnx, mny, mxx, mxy, lst, trg);
    @(negedge clk);
    triangle_s_valid = 1'b0;
    triangle_s_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    bbox_s_data      = {16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom())};
    nc = 1;
    while (exp_q.size() > 0 && nc < 400) begin
      case (mode)
        1: begin prdy = ($urandom_range(0, 3) != 0); trdy = 1'($urandom_range(0, 1)); end
        2: begin trdy = 1'b1; prdy = !(nb == 1 && stall < 3); if (!prdy) stall++; end
        3: begin prdy = 1'b1; trdy = !(attributed_triangle_m_valid && stall < 2); if (!trdy) stall++; end
        default: begin prdy = 1'b1; trdy = 1'b1; end
      endcase
      pixel_coordinate_m_ready    = prdy;
      attributed_triangle_m_ready = trdy;
      check("busy_scan", 320'(busy), 320'(1));
      if (pixel_coordinate_m_valid) begin
        cur = {attributed_triangle_m_valid, attributed_triangle_m_metadata.last,
               attributed_triangle_m_data, pixel_coordinate_m_data, pixel_coordinate_m_metadata.last};
        if (have_prev) check("hold_stable", cur, prev);
        xfer = prdy && (!attributed_triangle_m_valid || trdy);
        if (xfer) begin
          e = exp_q.pop_front();
          check("beat_pix",
                320'({pixel_coordinate_m_data.x, pixel_coordinate_m_data.y,
                      pixel_coordinate_m_metadata.last, attributed_triangle_m_valid}),
                320'({e.x, e.y, e.plast, e.tvalid}));
          if (e.tvalid)
            check("beat_trg", 320'({attributed_triangle_m_metadata.last, attributed_triangle_m_data}),
                  320'({e.tlast, e.trg}));
          if (nb == 0) begin fx = int'(pixel_coordinate_m_data.x); fy = int'(pixel_coordinate_m_data.y); end
          ex = int'(pixel_coordinate_m_data.x);
          ey = int'(pixel_coordinate_m_data.y);
          nb++;
          have_prev = 1'b0;
        end else begin
          prev      = cur;
          have_prev = 1'b1;
        end
      end
      @(negedge clk);
      nc++;
    end
    check("scan_done_left", 320'(exp_q.size()), 320'(0));
    check("s_ready_after", 320'(triangle_s_ready), 320'(1));
    check("busy_after", 320'(busy), 320'(0));
    check("pvalid_after", 320'(pixel_coordinate_m_valid), 320'(0));
  endtask

  vec_t tbl[9];
  int   nb, nc, fx, fy, ex, ey;

  initial begin
    tbl[0] = '{2, 3, 3, 4, 1, 4, 2, 3, 3, 4};
    tbl[1] = '{-5, -2, 20, 1, 0, 16, 0, 0, 7, 1};
    tbl[2] = '{0, 0, 3, 0, 0, 4, 0, 0, 3, 0};
    tbl[3] = '{5, 5, 3, 5, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{5, 5, 3, 5, 1, 1, 0, 0, 0, 0};
    tbl[5] = '{7, 7, 7, 7, 1, 1, 7, 7, 7, 7};
    tbl[6] = '{10, 10, 20, 20, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{-3, -3, -1, -1, 1, 1, 0, 0, 0, 0};
    tbl[8] = '{0, 6, 7, 9, 0, 16, 0, 6, 7, 7};

    rstn                        = 1'b0;
    triangle_s_valid            = 1'b0;
    triangle_s_data             = '0;
    triangle_s_metadata         = '0;
    bbox_s_data                 = '0;
    attributed_triangle_m_ready = 1'b0;
    pixel_coordinate_m_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 320'(triangle_s_ready), 320'(1));
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_valids", 320'({pixel_coordinate_m_valid, attributed_triangle_m_valid}), 320'(0));
    check("rst_data", 320'({attributed_triangle_m_data, attributed_triangle_m_metadata.last,
                             pixel_coordinate_m_data, pixel_coordinate_m_metadata.last}), 320'(0));
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_tri(tbl[i].mnx, tbl[i].mny, tbl[i].mxx, tbl[i].mxy, tbl[i].lst, 0, nb, nc, fx, fy, ex, ey);
      check("tbl_beats", 320'(nb), 320'(tbl[i].n));
      check("tbl_cycles", 320'(nc), 320'(tbl[i].n + 1));
      if (tbl[i].n > 0) begin
        check("tbl_first", 320'({fx, fy}), 320'({tbl[i].fx, tbl[i].fy}));
        check("tbl_end", 320'({ex, ey}), 320'({tbl[i].ex, tbl[i].ey}));
      end
    end

    run_tri(0, 0, 3, 0, 0, 2, nb, nc, fx, fy, ex, ey);
    check("stall_pix_beats", 320'(nb), 320'(4));
    check("stall_pix_cycles", 320'(nc), 320'(8));
    run_tri(7, 7, 7, 7, 1, 3, nb, nc, fx, fy, ex, ey);
    check("stall_trg_beats", 320'(nb), 320'(1));
    check("stall_trg_cycles", 320'(nc), 320'(4));

    // Reset in the middle of a 4x4 scan, then a fresh triangle must start at its own corner.
    @(negedge clk);
    pixel_coordinate_m_ready    = 1'b1;
    attributed_triangle_m_ready = 1'b1;
    drive_tri(0, 0, 3, 3, 0, '1);
    @(negedge clk);
    triangle_s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pvalid", 320'(pixel_coordinate_m_valid), 320'(1));
    rstn = 1'b0;
    #1;
    check("arst_valids", 320'({pixel_coordinate_m_valid, attributed_triangle_m_valid}), 320'(0));
    check("arst_s_ready", 320'(triangle_s_ready), 320'(1));
    check("arst_busy", 320'(busy), 320'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_tri(4, 4, 5, 5, 0, 0, nb, nc, fx, fy, ex, ey);
    check("post_rst_first", 320'({fx, fy}), 320'({32'sd4, 32'sd4}));
    check("post_rst_beats", 320'(nb), 320'(4));

    for (int r = 0; r < 40; r++) begin
      run_tri($urandom_range(0, 16) - 5, $urandom_range(0, 16) - 5,
              $urandom_range(0, 16) - 5, $urandom_range(0, 16) - 5,
              $urandom_range(0, 1), 1, nb, nc, fx, fy, ex, ey);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
